// File: rtl/apb_pwm_mc.sv
// apb_pwm_mc: NUM_CH-channel APB PWM generator with double-buffered DIV/PERIOD/DUTY per channel.
// Optional macro PWM_MC_IRQ_EN adds the STATUS register at 0xF0, CTRL.IE and the irq_o output.
module apb_pwm_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  PCLK_i,
    input  logic                  PRST_ni,
    input  logic                  PSEL_i,
    input  logic                  PENABLE_i,
    input  logic                  PWRITE_i,
    input  logic [ADDR_WIDTH-1:0] PADDR_i,
    input  logic [DATA_WIDTH-1:0] PWDATA_i,
    output logic [DATA_WIDTH-1:0] PRDATA_o,
    output logic                  PREADY_o,
    output logic                  PSLVERR_o,
    output logic [NUM_CH-1:0]     o_pwm_o,
    output logic [NUM_CH-1:0]     oe_pwm_o
`ifdef PWM_MC_IRQ_EN
    ,
    output logic                  irq_o
`endif
);

    localparam int CH_AW = ADDR_WIDTH - 4;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    logic              access, wr_acc, rd_acc;
    logic [CH_AW-1:0]  ch_idx;
    logic [1:0]        reg_idx;
    logic              ch_hit, stat_hit, addr_err;
    logic [NUM_CH-1:0] ch_wr;
    cnt_t              wdata_cnt;
    logic              unused_wdata;

    logic [NUM_CH-1:0] en_q, en_d, pol_q, pol_d, ie_v;
    logic [NUM_CH-1:0] tick, wrap;
    cnt_t div_sh_q   [NUM_CH], div_sh_d   [NUM_CH];
    cnt_t per_sh_q   [NUM_CH], per_sh_d   [NUM_CH];
    cnt_t duty_sh_q  [NUM_CH], duty_sh_d  [NUM_CH];
    cnt_t div_act_q  [NUM_CH], div_act_d  [NUM_CH];
    cnt_t per_act_q  [NUM_CH], per_act_d  [NUM_CH];
    cnt_t duty_act_q [NUM_CH], duty_act_d [NUM_CH];
    cnt_t pre_q      [NUM_CH], pre_d      [NUM_CH];
    cnt_t cnt_q      [NUM_CH], cnt_d      [NUM_CH];

`ifdef PWM_MC_IRQ_EN
    logic [NUM_CH-1:0] ie_q, ie_d, status_q, status_d, status_clr;
    logic              irq_q, irq_d;
    assign ie_v  = ie_q;
    assign irq_o = irq_q;
`else
    assign ie_v = '0;
`endif

    assign PREADY_o     = 1'b1;
    assign PSLVERR_o    = access & addr_err;
    assign unused_wdata = ^PWDATA_i;

    always_comb begin
        access    = PSEL_i & PENABLE_i;
        wr_acc    = access & PWRITE_i;
        rd_acc    = access & ~PWRITE_i;
        ch_idx    = PADDR_i[ADDR_WIDTH-1:4];
        reg_idx   = PADDR_i[3:2];
        ch_hit    = (PADDR_i[1:0] == 2'b00) && (int'(ch_idx) < NUM_CH);
`ifdef PWM_MC_IRQ_EN
        stat_hit  = (PADDR_i == ADDR_WIDTH'(8'hF0));
`else
        stat_hit  = 1'b0;
`endif
        addr_err  = ~(ch_hit | stat_hit);
        wdata_cnt = PWDATA_i[CNT_WIDTH-1:0];
        ch_wr     = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_wr[c] = wr_acc & ch_hit & (ch_idx == CH_AW'(c));
        end
    end

    always_comb begin
        PRDATA_o = '0;
        if (rd_acc && ch_hit) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_idx == CH_AW'(c)) begin
                    case (reg_idx)
                        2'd0:    PRDATA_o = DATA_WIDTH'({ie_v[c], pol_q[c], en_q[c]});
                        2'd1:    PRDATA_o = DATA_WIDTH'(div_sh_q[c]);
                        2'd2:    PRDATA_o = DATA_WIDTH'(per_sh_q[c]);
                        default: PRDATA_o = DATA_WIDTH'(duty_sh_q[c]);
                    endcase
                end
            end
        end
`ifdef PWM_MC_IRQ_EN
        if (rd_acc && stat_hit) begin
            PRDATA_o = DATA_WIDTH'(status_q);
        end
`endif
    end

    // Counter advance and wrap reloads are evaluated first so a CTRL write in the
    // same cycle overrides them; wrap reloads use the pre-write shadow values.
    always_comb begin
        en_d       = en_q;
        pol_d      = pol_q;
        div_sh_d   = div_sh_q;
        per_sh_d   = per_sh_q;
        duty_sh_d  = duty_sh_q;
        div_act_d  = div_act_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        tick       = '0;
        wrap       = '0;
`ifdef PWM_MC_IRQ_EN
        ie_d       = ie_q;
`endif
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_wr[c] && reg_idx == 2'd1) div_sh_d[c]  = wdata_cnt;
            if (ch_wr[c] && reg_idx == 2'd2) per_sh_d[c]  = wdata_cnt;
            if (ch_wr[c] && reg_idx == 2'd3) duty_sh_d[c] = wdata_cnt;

            if (en_q[c] && per_act_q[c] != '0) begin
                tick[c]  = (pre_q[c] == div_act_q[c]);
                wrap[c]  = tick[c] && (cnt_q[c] == per_act_q[c] - CNT_WIDTH'(1));
                pre_d[c] = tick[c] ? '0 : pre_q[c] + CNT_WIDTH'(1);
                if (tick[c]) begin
                    cnt_d[c] = wrap[c] ? '0 : cnt_q[c] + CNT_WIDTH'(1);
                end
                if (wrap[c]) begin
                    div_act_d[c]  = div_sh_q[c];
                    per_act_d[c]  = per_sh_q[c];
                    duty_act_d[c] = duty_sh_q[c];
                end
            end

            if (ch_wr[c] && reg_idx == 2'd0) begin
                pol_d[c] = PWDATA_i[1];
`ifdef PWM_MC_IRQ_EN
                ie_d[c]  = PWDATA_i[2];
`endif
                if (!PWDATA_i[0]) begin
                    en_d[c]  = 1'b0;
                    pre_d[c] = '0;
                    cnt_d[c] = '0;
                end else if (!en_q[c]) begin
                    en_d[c]       = 1'b1;
                    pre_d[c]      = '0;
                    cnt_d[c]      = '0;
                    div_act_d[c]  = div_sh_q[c];
                    per_act_d[c]  = per_sh_q[c];
                    duty_act_d[c] = duty_sh_q[c];
                end
            end
        end
    end

    always_comb begin
        oe_pwm_o = en_q;
        o_pwm_o  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (per_act_q[c] == '0) begin
                o_pwm_o[c] = en_q[c] & pol_q[c];
            end else begin
                o_pwm_o[c] = en_q[c] & ((cnt_q[c] < duty_act_q[c]) ^ pol_q[c]);
            end
        end
    end

    always_ff @(posedge PCLK_i or negedge PRST_ni) begin
        if (!PRST_ni) begin
            en_q  <= '0;
            pol_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                div_sh_q[c]   <= '0;
                per_sh_q[c]   <= '0;
                duty_sh_q[c]  <= '0;
                div_act_q[c]  <= '0;
                per_act_q[c]  <= '0;
                duty_act_q[c] <= '0;
                pre_q[c]      <= '0;
                cnt_q[c]      <= '0;
            end
        end else begin
            en_q       <= en_d;
            pol_q      <= pol_d;
            div_sh_q   <= div_sh_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            div_act_q  <= div_act_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef PWM_MC_IRQ_EN
    // A wrap in the same cycle as a W1C of that bit leaves it set.
    always_comb begin
        status_clr = (wr_acc && stat_hit) ? PWDATA_i[NUM_CH-1:0] : '0;
        status_d   = (status_q & ~status_clr) | wrap;
        irq_d      = |(status_q & ie_q);
    end

    always_ff @(posedge PCLK_i or negedge PRST_ni) begin
        if (!PRST_ni) begin
            ie_q     <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ie_q     <= ie_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_apb_pwm_mc.sv
// Scoreboard bench for apb_pwm_mc: pin and APB response expectations come from a
// period-position reference model; the IRQ/STATUS checks are active with PWM_MC_IRQ_EN.
`timescale 1ns/1ps
module tb_apb_pwm_mc;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NCH = 4;
    localparam int CW  = 16;

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic [NCH-1:0] oe;
        logic           irq;
    } pin_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic           psel    = 1'b0;
    logic           penable = 1'b0;
    logic           pwrite  = 1'b0;
    logic [AW-1:0]  paddr   = '0;
    logic [DW-1:0]  pwdata  = '0;
    logic [DW-1:0]  prdata;
    logic           pready, pslverr;
    logic [NCH-1:0] pwm, oe;
`ifdef PWM_MC_IRQ_EN
    logic           irq;
`endif

    pin_t pin_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: pos = clocks elapsed in the current PWM period.
    int m_en[NCH], m_pol[NCH], m_ie[NCH], m_st[NCH];
    int sh_div[NCH], sh_per[NCH], sh_duty[NCH];
    int a_div[NCH], a_per[NCH], a_duty[NCH], pos[NCH];
    int m_irq;

    apb_pwm_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
        .PCLK_i   (clk),
        .PRST_ni  (rst_n),
        .PSEL_i   (psel),
        .PENABLE_i(penable),
        .PWRITE_i (pwrite),
        .PADDR_i  (paddr),
        .PWDATA_i (pwdata),
        .PRDATA_o (prdata),
        .PREADY_o (pready),
        .PSLVERR_o(pslverr),
        .o_pwm_o  (pwm),
`ifdef PWM_MC_IRQ_EN
        .oe_pwm_o (oe),
        .irq_o    (irq)
`else
        .oe_pwm_o (oe)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [AW-1:0] a, output int err, output int ch, output int rg);
        ch  = int'(a[7:4]);
        rg  = int'(a[3:2]);
        err = (a[1:0] == 2'b00 && ch < NCH) ? 0 : 1;
`ifdef PWM_MC_IRQ_EN
        if (a == 8'hF0) begin
            err = 0;
            ch  = -1;
        end
`endif
    endfunction

    function automatic rsp_t model_rsp(input logic wr, input logic [AW-1:0] a);
        rsp_t r;
        int err, ch, rg;
        decode(a, err, ch, rg);
        r.err  = (err != 0);
        r.data = '0;
        if (err == 0 && !wr) begin
            if (ch < 0) begin
                for (int c = 0; c < NCH; c++) r.data[c] = (m_st[c] != 0);
            end else begin
                case (rg)
                    0:       r.data = DW'(m_en[ch] + 2 * m_pol[ch] + 4 * m_ie[ch]);
                    1:       r.data = DW'(sh_div[ch]);
                    2:       r.data = DW'(sh_per[ch]);
                    default: r.data = DW'(sh_duty[ch]);
                endcase
            end
        end
        return r;
    endfunction

    function automatic pin_t exp_pins();
        pin_t p;
        p = '0;
        for (int c = 0; c < NCH; c++) begin
            p.oe[c] = (m_en[c] != 0);
            if (m_en[c] != 0) begin
                if (a_per[c] == 0) p.pwm[c] = (m_pol[c] != 0);
                else p.pwm[c] = ((pos[c] / (a_div[c] + 1)) < a_duty[c]) ^ (m_pol[c] != 0);
            end
        end
        p.irq = (m_irq != 0);
        return p;
    endfunction

    always @(posedge clk) begin : model
        int err, ch, rg, irq_nx;
        int set_st[NCH];
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_pol[c] = 0; m_ie[c] = 0; m_st[c] = 0;
                sh_div[c] = 0; sh_per[c] = 0; sh_duty[c] = 0;
                a_div[c] = 0; a_per[c] = 0; a_duty[c] = 0; pos[c] = 0;
            end
            m_irq = 0;
        end else begin
            irq_nx = 0;
            for (int c = 0; c < NCH; c++) if (m_st[c] != 0 && m_ie[c] != 0) irq_nx = 1;
            for (int c = 0; c < NCH; c++) begin
                set_st[c] = 0;
                if (m_en[c] != 0 && a_per[c] != 0) begin
                    pos[c]++;
                    if (pos[c] == (a_div[c] + 1) * a_per[c]) begin
                        pos[c] = 0;
                        set_st[c] = 1;
                        a_div[c] = sh_div[c]; a_per[c] = sh_per[c]; a_duty[c] = sh_duty[c];
                    end
                end
            end
            if (psel && penable && pwrite) begin
                decode(paddr, err, ch, rg);
                if (err == 0) begin
                    if (ch < 0) begin
                        for (int c = 0; c < NCH; c++) if (pwdata[c]) m_st[c] = 0;
                    end else begin
                        case (rg)
                            0: begin
                                m_pol[ch] = int'(pwdata[1]);
`ifdef PWM_MC_IRQ_EN
                                m_ie[ch] = int'(pwdata[2]);
`endif
                                if (!pwdata[0]) begin
                                    m_en[ch] = 0;
                                    pos[ch] = 0;
                                end else if (m_en[ch] == 0) begin
                                    m_en[ch] = 1;
                                    pos[ch] = 0;
                                    a_div[ch] = sh_div[ch]; a_per[ch] = sh_per[ch]; a_duty[ch] = sh_duty[ch];
                                end
                            end
                            1: sh_div[ch]  = int'(pwdata[CW-1:0]);
                            2: sh_per[ch]  = int'(pwdata[CW-1:0]);
                            default: sh_duty[ch] = int'(pwdata[CW-1:0]);
                        endcase
                    end
                end
            end
            for (int c = 0; c < NCH; c++) if (set_st[c] != 0) m_st[c] = 1;
            m_irq = irq_nx;
        end
        pin_q.push_back(exp_pins());
    end

    always @(negedge clk) begin : monitor
        pin_t e;
        rsp_t r;
        if (pin_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL pin_queue: got empty queue, expected an entry at %0t", $time);
        end else begin
            e = pin_q.pop_front();
            chk("o_pwm", DW'(pwm), DW'(e.pwm));
            chk("oe_pwm", DW'(oe), DW'(e.oe));
`ifdef PWM_MC_IRQ_EN
            chk("irq", DW'(irq), DW'(e.irq));
`endif
        end
        if (psel && penable) begin
            chk("pready", DW'(pready), 1);
            if (rsp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL rsp_queue: got empty queue, expected an entry at %0t", $time);
            end else begin
                r = rsp_q.pop_front();
                chk("prdata", prdata, r.data);
                chk("pslverr", DW'(pslverr), DW'(r.err));
            end
        end
    end

    task automatic apb(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        rsp_q.push_back(model_rsp(wr, a));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb(0, 8'h00, 0);
        apb(0, 8'h34, 0);

        apb(1, 8'h04, 0);  apb(1, 8'h08, 10); apb(1, 8'h0C, 3); apb(1, 8'h00, 1);
        idle(40);
        apb(1, 8'h14, 1);  apb(1, 8'h18, 4);  apb(1, 8'h1C, 1); apb(1, 8'h10, 3);
        idle(40);
        idle(4);
        apb(1, 8'h0C, 5);  apb(0, 8'h0C, 0);
        idle(30);

        apb(1, 8'h28, 10); apb(1, 8'h2C, 12); apb(1, 8'h20, 1);
        apb(1, 8'h38, 10); apb(1, 8'h3C, 0);  apb(1, 8'h30, 1);
        idle(25);
        apb(1, 8'h28, 0);  apb(1, 8'h20, 0);  apb(1, 8'h20, 3);
        idle(15);

        apb(1, 8'h48, 32'h55); apb(0, 8'h48, 0); apb(1, 8'h02, 7); apb(0, 8'h0A, 0);
        apb(0, 8'h50, 0);      apb(1, 8'hF4, 1); apb(0, 8'hF0, 0);
        apb(0, 8'h08, 0);      apb(0, 8'h00, 0);

`ifdef PWM_MC_IRQ_EN
        apb(1, 8'h00, 0);  apb(1, 8'h10, 0);  apb(1, 8'h30, 0);
        apb(1, 8'h2C, 2);  apb(1, 8'h28, 5);  apb(1, 8'h20, 0); apb(1, 8'h20, 5);
        idle(12);
        apb(0, 8'hF0, 0);  apb(1, 8'hF0, 4);
        idle(3);
        apb(0, 8'hF0, 0);
        idle(10);
`endif

        for (int i = 0; i < 250; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int rg;
            rg = $urandom_range(0, 3);
            a  = {4'($urandom_range(0, NCH - 1)), 2'(rg), 2'b00};
            if ($urandom_range(0, 9) == 0) a = AW'($urandom);
            case (rg)
                0:       d = DW'($urandom_range(0, 7));
                1:       d = DW'($urandom_range(0, 2));
                2:       d = DW'($urandom_range(0, 9));
                default: d = DW'($urandom_range(0, 11));
            endcase
            apb($urandom_range(0, 3) != 0, a, d);
            idle($urandom_range(0, 5));
        end

        apb(1, 8'h04, 0);  apb(1, 8'h08, 10); apb(1, 8'h0C, 5);
        apb(1, 8'h00, 0);  apb(1, 8'h00, 1);
        idle(3);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", DW'(pwm), 0);
        chk("async_rst_oe", DW'(oe), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb(0, 8'h00, 0);
        apb(0, 8'h08, 0);
        idle(3);
        chk("rsp_queue_drained", DW'(rsp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/apb_pwm_mc.md
Name: apb_pwm_mc

Overview:
Multi-channel APB PWM generator; parametrised successor to the two-channel APB PWM peripheral.
- NUM_CH independent channels, each with its own prescaler, period and duty registers.
- Double-buffered timing registers take effect only at period boundaries, giving glitch-free updates.
- Sits on the peripheral APB bus; drives PWM pins through the pad mux (o_pwm_o / oe_pwm_o).

Parameters:
- DATA_WIDTH, 32, APB data width; also register width.
- ADDR_WIDTH, 8, APB byte-address width.
- NUM_CH, 4, number of PWM channels, 1..15.
- CNT_WIDTH, 16, width of the PERIOD, DUTY and DIV fields and of the counters; must be <= DATA_WIDTH.

Ports:
- PCLK_i  in  1  clock.
- PRST_ni  in  1  asynchronous active-low reset.
- PSEL_i  in  1  APB select.
- PENABLE_i  in  1  APB access phase.
- PWRITE_i  in  1  1 = write, 0 = read.
- PADDR_i  in  ADDR_WIDTH  byte address.
- PWDATA_i  in  DATA_WIDTH  write data.
- PRDATA_o  out  DATA_WIDTH  read data.
- PREADY_o  out  1  ready.
- PSLVERR_o  out  1  error response.
- o_pwm_o  out  NUM_CH  PWM outputs.
- oe_pwm_o  out  NUM_CH  output enables.
- irq_o  out  1  interrupt; present only with PWM_MC_IRQ_EN.

Behaviour:
- Clock is PCLK_i; reset PRST_ni is asynchronous, active-low. All registers, counters, outputs and status clear to 0 on reset.
- APB protocol:
  - Zero wait states: PREADY_o = 1 always.
  - Access occurs when PSEL_i & PENABLE_i; writes commit on that clock edge.
  - PRDATA_o is combinational during a read access, 0 otherwise.
- Address map, channel c base = c*0x10:
  - +0x0 CTRL: bit0 EN, bit1 POL.
  - +0x4 DIV.
  - +0x8 PERIOD.
  - +0xC DUTY.
  - 0xF0 STATUS: only with the macro.
- Address errors: unaligned (PADDR_i[1:0] != 0), channel >= NUM_CH, or unmapped address → PSLVERR_o = 1 in the access cycle. No state change; PRDATA_o = 0.
- Unused register bits read 0.
- Buffering: DIV, PERIOD and DUTY writes go to shadow registers, which reads return. Active copies load from the shadows:
  - at an EN 0→1 write edge, from the values present at that edge;
  - at every period wrap.
- Per-channel counters:
  - Prescaler counts 0..DIV_act. When it equals DIV_act it wraps to 0 and generates a tick.
  - Period counter advances on each tick over 0..PERIOD_act-1, then wraps.
  - Period wrap = tick while the period counter equals PERIOD_act-1.
  - Total period = (DIV_act+1)*PERIOD_act clocks.
- Output: o_pwm_o[c] = (cnt < DUTY_act) XOR POL, evaluated from registered state.
  - DUTY >= PERIOD → always active.
  - DUTY = 0 → always inactive.
  - PERIOD_act = 0 → counters held at 0; output = POL.
- Enable:
  - EN write 1 (from 0): counters reset to 0; the first PWM cycle starts the clock after the write.
  - EN write 0: counters cleared; o_pwm_o[c] = 0; oe_pwm_o[c] = 0 the next cycle.
  - oe_pwm_o[c] = EN.
- Re-writing EN = 1 while already enabled does not restart the counters; only POL updates, immediately.
- Simultaneous APB write to a shadow register and a period wrap in the same cycle: the active copy loads the old shadow value; the new value applies at the next wrap.

Optional Feature:
- Macro PWM_MC_IRQ_EN.
- Defined:
  - STATUS at 0xF0 holds NUM_CH sticky bits, set at each period wrap of the channel.
  - Writing 1 to a bit clears it (W1C). A set and a clear in the same cycle → bit stays set.
  - CTRL bit2 IE enables the channel's contribution.
  - irq_o = OR over c of (STATUS[c] & IE[c]), registered.
- Not defined:
  - No irq_o port and no STATUS register.
  - 0xF0 gives PSLVERR_o.
  - CTRL bit2 reads 0.

Test Plan:
- Ch0 DIV=0, PERIOD=10, DUTY=3, EN=1 → o_pwm_o[0] repeats 3 clocks high, 7 low; oe_pwm_o[0] = 1; other channels stay 0.
- Ch1 DIV=1, PERIOD=4, DUTY=1, POL=1 → 8-clock period: 2 clocks low, 6 high.
- Ch0 running DUTY=3 → write DUTY=5 mid-period: current period keeps 3 high clocks, next period 5; readback returns 5 immediately.
- DUTY=12 with PERIOD=10 → constant 1. DUTY=0 → constant 0. PERIOD=0 → constant POL.
- Read/write 0x08 with NUM_CH=4 channel 4 (0x48), plus unaligned 0x02 → PSLVERR_o = 1, PRDATA_o = 0, registers unchanged. PRST_ni low mid-period → all outputs 0 asynchronously.
- PWM_MC_IRQ_EN: ch2 PERIOD=5, IE=1 → irq_o rises 1 clock after the first wrap. W1C STATUS bit2 → irq_o falls, then re-asserts after the next wrap.
